// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned matrix keypad, whole-image debounce, event FIFO.
// Define KEYPAD_RELEASE_EVENTS_EN to also queue key-release events.
module keypad_scanner #(
  parameter int NROW       = 4,
  parameter int NCOL       = 4,
  parameter int KEYW       = 4,
  parameter int NSETTLE    = 10,
  parameter int NDEB       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [NROW-1:0] o_row,
  input  logic [NCOL-1:0] i_col,
  output logic            o_key_valid,
  output logic [KEYW-1:0] o_key_code,
  output logic            o_key_up,
  input  logic            i_key_ready,
  output logic            o_ovf
);

  localparam int NK = NROW * NCOL;
  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int SW = $clog2(NDEB);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [RW-1:0]   LAST_ROW   = RW'(NROW - 1);
  localparam logic [KEYW-1:0] LAST_KEY   = KEYW'(NK - 1);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(NDEB - 1);

  typedef enum logic [1:0] {
    S_DRIVE,
    S_SAMPLE,
    S_COMPARE,
    S_EMIT
  } state_e;

  state_e              state_q, state_d;
  logic                run_q;
  logic [RW-1:0]       row_q, row_d;
  logic [NSETTLE-1:0]  settle_q, settle_d;
  logic [KEYW-1:0]     key_q, key_d;
  logic [SW-1:0]       stable_q, stable_d;
  logic [NK-1:0]       new_img_q, new_img_d;
  logic [NK-1:0]       prev_img_q, prev_img_d;
  logic [NK-1:0]       deb_img_q, deb_img_d;
  logic [NROW-1:0]     row_out_q, row_out_d;
  logic [NCOL-1:0]     col_s1_q, col_s2_q;

  logic                key_img;
  logic                key_deb;
  logic                key_chg;
  logic                push;

  assign key_img = prev_img_q[key_q];
  assign key_deb = deb_img_q[key_q];

`ifdef KEYPAD_RELEASE_EVENTS_EN
  assign key_chg = key_img ^ key_deb;
`else
  assign key_chg = key_img & ~key_deb;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= i_col;
      col_s2_q <= col_s1_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_DRIVE;
      run_q      <= 1'b0;
      row_q      <= '0;
      settle_q   <= '0;
      key_q      <= '0;
      stable_q   <= '0;
      new_img_q  <= '0;
      prev_img_q <= '0;
      deb_img_q  <= '0;
      row_out_q  <= '1;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      row_q      <= row_d;
      settle_q   <= settle_d;
      key_q      <= key_d;
      stable_q   <= stable_d;
      new_img_q  <= new_img_d;
      prev_img_q <= prev_img_d;
      deb_img_q  <= deb_img_d;
      row_out_q  <= row_out_d;
    end
  end

  // The first cycle out of reset only loads the row drive, so row 0
  // is held for a full settle window like every other row.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    settle_d   = settle_q;
    key_d      = key_q;
    stable_d   = stable_q;
    new_img_d  = new_img_q;
    prev_img_d = prev_img_q;
    deb_img_d  = deb_img_q;
    push       = 1'b0;
    if (run_q) begin
      unique case (state_q)
        S_DRIVE: begin
          settle_d = settle_q + 1'b1;
          if (settle_q == '1) state_d = S_SAMPLE;
        end
        S_SAMPLE: begin
          new_img_d[int'(row_q)*NCOL +: NCOL] = ~col_s2_q;
          if (row_q == LAST_ROW) begin
            state_d = S_COMPARE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_DRIVE;
          end
        end
        S_COMPARE: begin
          row_d = '0;
          if (new_img_q != prev_img_q) begin
            prev_img_d = new_img_q;
            stable_d   = '0;
          end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 1'b1;
          end
          if (stable_d == STABLE_MAX && new_img_q != deb_img_q) begin
            state_d = S_EMIT;
            key_d   = '0;
          end else begin
            state_d = S_DRIVE;
          end
        end
        S_EMIT: begin
          push = key_chg;
          if (key_q == LAST_KEY) begin
            deb_img_d = prev_img_q;
            state_d   = S_DRIVE;
          end else begin
            key_d = key_q + 1'b1;
          end
        end
        default: state_d = S_DRIVE;
      endcase
    end
  end

  always_comb begin
    row_out_d = '1;
    if (state_d == S_DRIVE || state_d == S_SAMPLE) begin
      row_out_d = ~(NROW'(1) << row_d);
    end
  end

  assign o_row = row_out_q;

  logic [KEYW-1:0] code_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            full;
  logic            pop;
  logic            wr_en;

  assign o_key_valid = (cnt_q != '0);
  assign full        = (cnt_q == CW'(FIFO_DEPTH));
  assign pop         = o_key_valid & i_key_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign wr_en       = push & (~full | pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (wr_en && !pop) cnt_q <= cnt_q + 1'b1;
      if (pop && !wr_en) cnt_q <= cnt_q - 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) code_mem_q[wr_q] <= key_q;
  end

  assign o_key_code = o_key_valid ? code_mem_q[rd_q] : '0;
  assign o_ovf      = ovf_q;

`ifdef KEYPAD_RELEASE_EVENTS_EN
  logic up_mem_q [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) up_mem_q[wr_q] <= ~key_img;
  end

  assign o_key_up = o_key_valid & up_mem_q[rd_q];
`else
  assign o_key_up = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a
// simulated switch matrix; NSETTLE=2, NDEB=2 gives 21-cycle scans.
module tb_keypad_scanner;

  localparam int SCAN = 21;
  localparam int NK   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        valid;
  logic [3:0]  code;
  logic        up;
  logic        ready;
  logic        ovf;
  logic [15:0] keys;

  logic [4:0]  exp_q[$];
  logic [4:0]  head;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .NROW(4), .NCOL(4), .KEYW(4),
    .NSETTLE(2), .NDEB(2), .FIFO_DEPTH(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_row      (row),
    .i_col      (col),
    .o_key_valid(valid),
    .o_key_code (code),
    .o_key_up   (up),
    .i_key_ready(ready),
    .o_ovf      (ovf)
  );

  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event got code=%0d up=%0d, expected none",
                 code, up);
      end else begin
        head = exp_q.pop_front();
        if ({code, up} !== head) begin
          miscompares++;
          $display("FAIL event got code=%0d up=%0d, expected code=%0d up=%0d",
                   code, up, head[4:1], head[0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    logic [3:0] er;
    int bad_valid = 0;
    rst   = 1'b1;
    keys  = '0;
    ready = 1'b1;
    step(3);
    vectors++;
    if (row !== 4'hF || valid !== 1'b0 || ovf !== 1'b0 ||
        code !== 4'h0 || up !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state row=%b valid=%b ovf=%b code=%0d up=%b, expected 1111 0 0 0 0",
               row, valid, ovf, code, up);
    end
    rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      er = (i < 20) ? ~(4'b0001 << (i / 5)) : 4'hF;
      vectors++;
      if (row !== er) begin
        miscompares++;
        $display("FAIL row_walk cycle %0d row=%b, expected %b", i, row, er);
      end
      if (valid !== 1'b0) bad_valid++;
    end
    vectors++;
    if (bad_valid != 0) begin
      miscompares++;
      $display("FAIL reset_idle_valid valid high %0d cycles, expected 0",
               bad_valid);
    end
  endtask

  task automatic test_single_press();
    bit ok;
    step(1);
    keys[6] = 1'b1;
    exp_q.push_back({4'd6, 1'b0});
    drain(3*SCAN + NK, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_press_latency pending=%0d, expected 0 within %0d cycles",
               exp_q.size(), 3*SCAN + NK);
    end
    step(10*SCAN);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL hold_no_repeat valid=%b pending=%0d, expected 0 0",
               valid, exp_q.size());
    end
  endtask

  task automatic test_release();
    bit ok;
    step(1);
    keys[6] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    exp_q.push_back({4'd6, 1'b1});
`endif
    step(4*SCAN + NK);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL release valid=%b pending=%0d, expected 0 0",
               valid, exp_q.size());
    end
    keys[6] = 1'b1;
    exp_q.push_back({4'd6, 1'b0});
    drain(4*SCAN + NK, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL repress pending=%0d, expected 0", exp_q.size());
    end
    step(SCAN);
    keys[6] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    exp_q.push_back({4'd6, 1'b1});
`endif
    step(4*SCAN + NK);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL release2 valid=%b pending=%0d, expected 0 0",
               valid, exp_q.size());
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int seen = 0;
    step(1);
    for (int i = 0; i < 6; i++) begin
      keys[6] = (i % 2 == 0);
      for (int j = 0; j < SCAN; j++) begin
        step(1);
        if (valid === 1'b1) seen++;
      end
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL bounce_quiet valid high %0d cycles, expected 0", seen);
    end
    keys[6] = 1'b1;
    exp_q.push_back({4'd6, 1'b0});
    drain(3*SCAN + NK, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bounce_accept pending=%0d, expected 0", exp_q.size());
    end
    step(3*SCAN);
    keys[6] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    exp_q.push_back({4'd6, 1'b1});
`endif
    step(4*SCAN + NK);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bounce_release valid=%b pending=%0d, expected 0 0",
               valid, exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    step(1);
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    exp_q.push_back({4'd0, 1'b0});
    exp_q.push_back({4'd15, 1'b0});
    drain(4*SCAN + NK, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL simultaneous pending=%0d, expected 0", exp_q.size());
    end
    keys[0]  = 1'b0;
    keys[15] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    exp_q.push_back({4'd0, 1'b1});
    exp_q.push_back({4'd15, 1'b1});
`endif
    step(4*SCAN + NK);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL simultaneous_release valid=%b pending=%0d, expected 0 0",
               valid, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    step(1);
    ready = 1'b0;
    keys  = 16'h003E;
    for (int k = 1; k <= 4; k++) exp_q.push_back({4'(k), 1'b0});
    step(4*SCAN + NK);
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set ovf=%b, expected 1", ovf);
    end
    vectors++;
    if (valid !== 1'b1 || code !== 4'd1) begin
      miscompares++;
      $display("FAIL ovf_head valid=%b code=%0d, expected 1 1", valid, code);
    end
    ready = 1'b1;
    drain(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ovf_drain pending=%0d, expected 0", exp_q.size());
    end
    step(2*SCAN);
    vectors++;
    if (ovf !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky ovf=%b valid=%b, expected 1 0", ovf, valid);
    end
    keys = '0;
`ifdef KEYPAD_RELEASE_EVENTS_EN
    for (int k = 1; k <= 5; k++) exp_q.push_back({4'(k), 1'b1});
`endif
    step(4*SCAN + NK);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_release valid=%b pending=%0d ovf=%b, expected 0 0 1",
               valid, exp_q.size(), ovf);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    step(1);
    ready   = 1'b0;
    keys[9] = 1'b1;
    while (valid !== 1'b1 && n < 4*SCAN + NK) begin
      step(1);
      n++;
    end
    vectors++;
    if (valid !== 1'b1 || code !== 4'd9) begin
      miscompares++;
      $display("FAIL midrun_event valid=%b code=%0d, expected 1 9", valid, code);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (row !== 4'hF || valid !== 1'b0 || ovf !== 1'b0 || code !== 4'h0) begin
      miscompares++;
      $display("FAIL midrun_reset row=%b valid=%b ovf=%b code=%0d, expected 1111 0 0 0",
               row, valid, ovf, code);
    end
    keys = '0;
    step(2);
    rst   = 1'b0;
    ready = 1'b1;
    step(3*SCAN);
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL midrun_quiet valid=%b pending=%0d, expected 0 0",
               valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad controller for the DE10-Lite GPIO header. It sequences row drive and column sampling over an NROW×NCOL switch matrix, debounces the whole matrix with a single shared scan-image comparator, and queues press/release events in a small FIFO. Consumers read events through a valid/ready handshake. It sits between the raw GPIO pins and application logic, in the same role the per-switch debouncers play for on-board switches.

## Interface
- NROW, 4: number of matrix rows.
- NCOL, 4: number of matrix columns.
- KEYW, 4: key-code width. Requires NROW*NCOL ≤ 2^KEYW.
- NSETTLE, 10: settle time per row is 2^NSETTLE cycles. Minimum 2.
- NDEB, 8: number of consecutive identical full scans required to accept a change. Minimum 2.
- FIFO_DEPTH, 4: event FIFO entries, power of two.

- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- o_row  out  NROW  active-low row drive, at most one bit low.
- i_col  in  NCOL  active-low raw column inputs, asynchronous to i_clk.
- o_key_valid  out  1  FIFO head holds an event.
- o_key_code  out  KEYW  head event key index, row*NCOL+col.
- o_key_up  out  1  head event type: 1 = release, 0 = press.
- i_key_ready  in  1  consumer accepts the head event.
- o_ovf  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- i_col passes through a 2-flop synchronizer. The scan logic uses only the synchronized value.
- The image bit for key (r,c) is 1 (pressed) when col c is low while row r is driven.
- FSM states:
  - DRIVE: drive row r low; count 2^NSETTLE cycles; then go to SAMPLE.
  - SAMPLE: 1 cycle; latch the synchronized columns into row r of the new image. If r<NROW-1, increment r and go to DRIVE. Otherwise go to COMPARE.
  - COMPARE: 1 cycle; o_row all ones.
    - If the new image ≠ the previous image, store it and clear stable_cnt.
    - If it is equal, stable_cnt saturates-increments.
    - If stable_cnt reaches NDEB-1 and the image ≠ the debounced image, go to EMIT. Otherwise set r=0 and go to DRIVE.
  - EMIT: NROW*NCOL cycles with o_row all ones. Step key index k from 0 upward.
    - Each cycle where the debounced bit differs from the image bit pushes one event: code k, up = ~image bit.
    - At the end, debounced image := image, r=0, go to DRIVE.
- Events are emitted in ascending key-index order. Any number of simultaneous changes is supported.
- FIFO behaviour:
  - The head is exposed on o_key_*. A transfer occurs when o_key_valid & i_key_ready.
  - A push while full with no pop in the same cycle drops the event and sets o_ovf.
  - A push and pop in the same cycle while full is accepted, with no overflow.
  - o_ovf clears only on reset.
- Reset at any point asynchronously restores reset state. The FIFO is emptied, all images and counters are cleared, and no partial event is output.

## Timing
- Reset values: o_row all ones, o_key_valid 0, o_key_code 0, o_key_up 0, o_ovf 0, r 0, stable_cnt 0, all images 0.
- First cycle after i_rst deasserts: FSM in DRIVE with o_row = ~(1<<0).
- One scan lasts NROW*(2^NSETTLE+1)+1 cycles, plus NROW*NCOL cycles when EMIT runs.
- Minimum accept latency from a stable contact change: the change first appears in a scan image, then NDEB-1 further identical scans, then COMPARE, then EMIT reaches key k. An event is pushed in EMIT cycle k and o_key_valid rises the next cycle if the FIFO was empty.
- Held keys produce no repeat events.

## Configuration
- KEYPAD_RELEASE_EVENTS_EN defined: release transitions push events with o_key_up=1.
- KEYPAD_RELEASE_EVENTS_EN undefined:
  - Only press transitions are pushed, and o_key_up is constant 0.
  - The debounced image still tracks releases, so a re-press generates a new event.

## Test plan
Overrides for all scenarios: NSETTLE=2, NDEB=2, giving scans of 21 cycles.
- Reset rotation: pulse i_rst with no keys pressed.
  - During reset, o_row=1111.
  - After release, o_row walks 1110, 1101, 1011, 0111 for 5 cycles each, then 1111 for 1 cycle.
  - o_key_valid stays 0.
- Single press: hold key 6 (row 1, col 2).
  - Exactly one event appears: code=6, up=0, valid within 3 scans.
  - Holding key 6 for 10 more scans produces no further events.
- Bounce rejection: toggle key 6 on every scan for 6 scans, then hold it.
  - No event appears during toggling.
  - Exactly one press event appears after 2 identical scans.
- Simultaneous keys: press keys 0 and 15 in the same scan.
  - Events pop in order: code 0, then code 15, both up=0.
- Overflow: hold i_key_ready=0 and generate 5 press events with FIFO_DEPTH=4.
  - o_ovf=1 and the 5th event is dropped.
  - With ready=1, 4 events drain in ascending order and o_ovf stays 1.
- Release, with and without the macro: release key 6 after an accepted press.
  - With KEYPAD_RELEASE_EVENTS_EN: event code=6, up=1.
  - Without it: no event. A subsequent re-press yields a new code=6 event.
